// File: rtl/dbi_rx_decoder.sv
// DBI receive stage: restores the payload byte from a 9-bit coded word and buffers it in a valid/ready FIFO.
// Optional link statistics are built when DBI_RX_STATS_EN is defined.
module dbi_rx_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_u,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] inv_cnt,
    output logic [CNT_W-1:0] tog_cnt,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  decoded;

    assign decoded   = in_v[8:1] ^ {8{in_v[0]}};
    // Same index with different wrap bits means the writer is a full lap ahead.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_u     = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= decoded;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef DBI_RX_STATS_EN
    logic [8:0] bus_prev;
    logic [8:0] diff;
    logic [3:0] tog_num;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W+3:0] s;
        s = {4'b0000, a} + {{CNT_W{1'b0}}, b};
        return (s > {4'b0000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign diff = in_v ^ bus_prev;

    // NOTE: the accumulator gets a default before the loop so no latch is inferred.
    always_comb begin
        tog_num = 4'd0;
        for (int i = 0; i < 9; i++) begin
            tog_num = tog_num + 4'(diff[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_prev <= 9'h000;
            word_cnt <= '0;
            inv_cnt  <= '0;
            tog_cnt  <= '0;
            viol_cnt <= '0;
        end else begin
            if (push) bus_prev <= in_v;
            // A clear wins over a same-cycle accept; that word is not counted.
            if (clr_stats) begin
                word_cnt <= '0;
                inv_cnt  <= '0;
                tog_cnt  <= '0;
                viol_cnt <= '0;
            end else if (push) begin
                word_cnt <= sat_add(word_cnt, 4'd1);
                tog_cnt  <= sat_add(tog_cnt, tog_num);
                if (in_v[0])       inv_cnt  <= sat_add(inv_cnt, 4'd1);
                if (tog_num > 4'd4) viol_cnt <= sat_add(viol_cnt, 4'd1);
            end
        end
    end
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign word_cnt = '0;
    assign inv_cnt  = '0;
    assign tog_cnt  = '0;
    assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_dbi_rx_decoder.sv
// Self-checking bench for dbi_rx_decoder: decode table, directed corner sequences and a randomized run
// against a queue-based reference model.
module tb_dbi_rx_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef DBI_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_v;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_u;
    logic             clr_stats;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] inv_cnt;
    logic [CNT_W-1:0] tog_cnt;
    logic [CNT_W-1:0] viol_cnt;

    dbi_rx_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_v(in_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u),
        .clr_stats(clr_stats),
        .word_cnt(word_cnt), .inv_cnt(inv_cnt), .tog_cnt(tog_cnt), .viol_cnt(viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [8:0] m_prev;
    int m_word, m_inv, m_tog, m_viol;

    typedef struct {
        logic [8:0] v;
        logic [7:0] u;
    } dec_vec_t;
    dec_vec_t dec_tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] decode(input logic [8:0] v);
        return v[0] ? ~v[8:1] : v[8:1];
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic int sexp(input int x);
        return STATS ? x : 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prev = 9'h000;
        m_word = 0; m_inv = 0; m_tog = 0; m_viol = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check({tag, "_out_u"}, 32'(out_u), 32'(mq[0]));
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'(sexp(m_word)));
        check({tag, "_inv_cnt"},  32'(inv_cnt),  32'(sexp(m_inv)));
        check({tag, "_tog_cnt"},  32'(tog_cnt),  32'(sexp(m_tog)));
        check({tag, "_viol_cnt"}, 32'(viol_cnt), 32'(sexp(m_viol)));
    endtask

    // Inputs are set while clk is low; the model advances at the edge and is compared at the next negedge.
    task automatic cycle(input string tag);
        bit acc, pp;
        int t;
        acc = in_valid && (mq.size() < DEPTH);
        pp  = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(decode(in_v));
            t = $countones(in_v ^ m_prev);
            m_prev = in_v;
        end
        if (clr_stats) begin
            m_word = 0; m_inv = 0; m_tog = 0; m_viol = 0;
        end else if (acc) begin
            m_word = sat(m_word + 1);
            m_tog  = sat(m_tog + t);
            if (in_v[0]) m_inv  = sat(m_inv + 1);
            if (t > 4)   m_viol = sat(m_viol + 1);
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_v = 9'h000; out_ready = 1'b0; clr_stats = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_u", 32'(out_u), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cnts", {word_cnt, inv_cnt, tog_cnt, viol_cnt}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic push_word(input logic [8:0] v, input string tag);
        in_valid = 1'b1;
        in_v = v;
        cycle(tag);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] w [5];
        logic [7:0] got[$];
        int sent;
        bit a;

        dec_tab[0] = '{9'h0AA, 8'h55};
        dec_tab[1] = '{9'h155, 8'h55};
        dec_tab[2] = '{9'h000, 8'h00};
        dec_tab[3] = '{9'h001, 8'hFF};
        dec_tab[4] = '{9'h1FE, 8'hFF};
        dec_tab[5] = '{9'h1FF, 8'h00};
        dec_tab[6] = '{9'h0F0, 8'h78};
        dec_tab[7] = '{9'h0F1, 8'h87};

        do_reset();

        // Decode table with a streaming consumer
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_v = dec_tab[i].v;
            cycle("dec");
            check("dec_tab", 32'(out_u), 32'(dec_tab[i].u));
        end
        in_valid = 1'b0;
        cycle("dec_drain");
        check("dec_empty", 32'(out_valid), 32'd0);

        // Backpressure: fill, hold the fifth word, then drain in order
        do_reset();
        w[0] = 9'h0A1; w[1] = 9'h13C; w[2] = 9'h0FF; w[3] = 9'h100; w[4] = 9'h055;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_v = w[sent];
            a = in_ready;
            cycle("bp_fill");
            if (a) sent++;
        end
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_sent", 32'(sent), 32'd4);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            in_valid = (sent < 5);
            in_v = w[(sent < 5) ? sent : 4];
            a = in_ready && in_valid;
            if (out_valid) got.push_back(out_u);
            cycle("bp_drain");
            if (a) sent++;
        end
        check("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check("bp_order", 32'(got[i]), 32'(decode(w[i])));
        end
        in_valid = 1'b0;

        // Stats basics
        do_reset();
        out_ready = 1'b1;
        push_word(9'h1FF, "st");
        push_word(9'h1FE, "st");
        check("st_word", 32'(word_cnt), 32'(sexp(2)));
        check("st_inv",  32'(inv_cnt),  32'(sexp(1)));
        check("st_tog",  32'(tog_cnt),  32'(sexp(10)));
        check("st_viol", 32'(viol_cnt), 32'(sexp(1)));

        // Saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word((i % 2 == 0) ? 9'h001 : 9'h1FF, "sat");
        repeat (2) cycle("sat_hold");
        check("sat_word", 32'(word_cnt), 32'(sexp(15)));
        check("sat_inv",  32'(inv_cnt),  32'(sexp(15)));
        check("sat_tog",  32'(tog_cnt),  32'(sexp(15)));
        check("sat_viol", 32'(viol_cnt), 32'(sexp(15)));

        // Reset mid-operation
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(9'h1FF, "mr");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_cnts", {word_cnt, inv_cnt, tog_cnt, viol_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push_word(9'h003, "mr_post");
        check("mr_tog", 32'(tog_cnt), 32'(sexp(2)));

        // clr_stats colliding with an accept
        do_reset();
        out_ready = 1'b1;
        push_word(9'h0F0, "clr_pre");
        clr_stats = 1'b1;
        push_word(9'h1FF, "clr");
        clr_stats = 1'b0;
        check("clr_cnts", {word_cnt, inv_cnt, tog_cnt, viol_cnt}, 32'd0);
        push_word(9'h1FE, "clr_post");
        check("clr_tog",  32'(tog_cnt),  32'(sexp(1)));
        check("clr_word", 32'(word_cnt), 32'(sexp(1)));
        check("clr_viol", 32'(viol_cnt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_v      = 9'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_stats = ($urandom_range(0, 31) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
